cpu_debug_ctrl: RTL and testbench

//  Input-side companion to the register display path: conditions the 4 active-low board buttons and

---
 rtl/cpu_debug_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_cpu_debug_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_debug_ctrl.sv
// cpu_debug_ctrl: conditions the four active-low board buttons and drives
// run/halt, single-instruction step, soft CPU reset and the register-display
// select into the 6502 core.
module cpu_debug_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned RST_CYCLES      = 16,
  parameter bit          START_RUN       = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn_n,
  input  logic       cpu_sync,
  output logic       cpu_en,
  output logic       cpu_rst,
  output logic [1:0] disp_sel,
  output logic       halted,
  output logic [3:0] btn_db
);

  localparam int unsigned       RC_W     = $clog2(RST_CYCLES + 1);
  localparam logic [CNT_W-1:0]  DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RC_W-1:0]   RST_LOAD = RC_W'(RST_CYCLES);

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_HALT_PEND = 2'd1,
    ST_HALTED    = 2'd2,
    ST_STEP      = 2'd3
  } state_e;

  localparam state_e ST_START = START_RUN ? ST_RUN : ST_HALTED;

  // Button conditioning state
  logic [3:0]       sync1_q, sync1_d;
  logic [3:0]       sync2_q, sync2_d;
  logic [3:0]       pressed_s;
  logic [3:0]       db_q, db_d;
  logic [3:0]       evt_q, evt_d;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];

  // Core control state
  state_e           state_q, state_d;
  logic             step_flag_q, step_flag_d;
  logic [RC_W-1:0]  rst_cnt_q, rst_cnt_d;
  logic             cpu_rst_q, cpu_rst_d;
  logic [1:0]       disp_sel_q, disp_sel_d;
  logic             halted_q, halted_d;

  // Synchroniser chain: the raw pins are asynchronous to clk.
  always_comb begin
    sync1_d   = btn_n;
    sync2_d   = sync1_q;
    pressed_s = ~sync2_q;
  end

  // Per-button debounce: a level change is accepted only after DEBOUNCE_CYCLES
  // consecutive disagreeing samples; only the press edge produces an event.
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (pressed_s[i] == db_q[i]) begin
        cnt_d[i] = {CNT_W{1'b0}};
      end else if (cnt_q[i] == DB_LAST) begin
        cnt_d[i] = {CNT_W{1'b0}};
        db_d[i]  = ~db_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
    evt_d = db_d & ~db_q;
  end

  // Core clock-enable: in HALT_PEND and STEP the core is frozen on the
  // opcode-fetch cycle so the fetched instruction is not executed.
  always_comb begin
    cpu_en = 1'b0;
    case (state_q)
      ST_RUN:       cpu_en = 1'b1;
      ST_HALT_PEND: cpu_en = ~cpu_sync;
      ST_HALTED:    cpu_en = 1'b0;
      ST_STEP:      cpu_en = ~(cpu_sync & step_flag_q);
      default:      cpu_en = 1'b0;
    endcase
  end

  // Run/halt/step sequencing; a soft-reset event overrides the other buttons.
  always_comb begin
    state_d     = state_q;
    step_flag_d = step_flag_q;
    if (evt_q[3]) begin
      state_d     = ST_START;
      step_flag_d = 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (evt_q[0]) begin
            state_d = ST_HALT_PEND;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_HALT_PEND: begin
          if (cpu_sync) begin
            state_d = ST_HALTED;
          end else begin
            state_d = ST_HALT_PEND;
          end
        end
        ST_HALTED: begin
          step_flag_d = 1'b0;
          if (evt_q[0]) begin
            state_d = ST_RUN;
          end else if (evt_q[1]) begin
            state_d = ST_STEP;
          end else begin
            state_d = ST_HALTED;
          end
        end
        ST_STEP: begin
          // The flag marks that the core has left the starting fetch cycle,
          // so the next fetch belongs to the following instruction.
          if (cpu_en && !cpu_sync) begin
            step_flag_d = 1'b1;
          end else begin
            step_flag_d = step_flag_q;
          end
          if (cpu_sync && step_flag_q) begin
            state_d = ST_HALTED;
          end else begin
            state_d = ST_STEP;
          end
        end
        default: begin
          state_d     = ST_START;
          step_flag_d = 1'b0;
        end
      endcase
    end
  end

  // Display select, soft-reset pulse counter and registered status outputs.
  always_comb begin
    if (evt_q[2]) begin
      disp_sel_d = disp_sel_q + 2'd1;
    end else begin
      disp_sel_d = disp_sel_q;
    end
    if (evt_q[3]) begin
      rst_cnt_d = RST_LOAD;
    end else if (rst_cnt_q != {RC_W{1'b0}}) begin
      rst_cnt_d = rst_cnt_q - RC_W'(1);
    end else begin
      rst_cnt_d = rst_cnt_q;
    end
    cpu_rst_d = (rst_cnt_d != {RC_W{1'b0}});
    halted_d  = (state_d == ST_HALTED);
  end

  // State registers, all cleared asynchronously to their idle values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q     <= 4'hF;
      sync2_q     <= 4'hF;
      db_q        <= 4'h0;
      evt_q       <= 4'h0;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= {CNT_W{1'b0}};
      end
      state_q     <= ST_START;
      step_flag_q <= 1'b0;
      rst_cnt_q   <= {RC_W{1'b0}};
      cpu_rst_q   <= 1'b0;
      disp_sel_q  <= 2'd0;
      halted_q    <= (ST_START == ST_HALTED);
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      db_q        <= db_d;
      evt_q       <= evt_d;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      state_q     <= state_d;
      step_flag_q <= step_flag_d;
      rst_cnt_q   <= rst_cnt_d;
      cpu_rst_q   <= cpu_rst_d;
      disp_sel_q  <= disp_sel_d;
      halted_q    <= halted_d;
    end
  end

  assign cpu_rst  = cpu_rst_q;
  assign disp_sel = disp_sel_q;
  assign halted   = halted_q;
  assign btn_db   = db_q;

endmodule

// File: tb/tb_cpu_debug_ctrl.sv
// Directed self-checking bench for cpu_debug_ctrl with
// DEBOUNCE_CYCLES=4, RST_CYCLES=3, START_RUN=1.
// Inputs change on the falling edge; outputs are checked 1 time unit later.
// Cycle k of a press means the input was driven at the k-th falling edge
// after the press began; a clean press shows up on btn_db at k=6 and its
// event acts on the FSM at the edge that makes k=7 visible.
module tb_cpu_debug_ctrl;

  logic       clk;
  logic       reset;
  logic [3:0] btn_n;
  logic       cpu_sync;
  logic       cpu_en;
  logic       cpu_rst;
  logic [1:0] disp_sel;
  logic       halted;
  logic [3:0] btn_db;

  int n_cmp;
  int n_err;

  cpu_debug_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (16),
    .RST_CYCLES     (3),
    .START_RUN      (1'b1)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .btn_n   (btn_n),
    .cpu_sync(cpu_sync),
    .cpu_en  (cpu_en),
    .cpu_rst (cpu_rst),
    .disp_sel(disp_sel),
    .halted  (halted),
    .btn_db  (btn_db)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    n_cmp++; if (cpu_en !== 1'b1)   begin n_err++; $display("FAIL rst_cpu_en got=%b exp=1", cpu_en); end
    n_cmp++; if (cpu_rst !== 1'b0)  begin n_err++; $display("FAIL rst_cpu_rst got=%b exp=0", cpu_rst); end
    n_cmp++; if (disp_sel !== 2'd0) begin n_err++; $display("FAIL rst_disp_sel got=%0d exp=0", disp_sel); end
    n_cmp++; if (halted !== 1'b0)   begin n_err++; $display("FAIL rst_halted got=%b exp=0", halted); end
    n_cmp++; if (btn_db !== 4'h0)   begin n_err++; $display("FAIL rst_btn_db got=%h exp=0", btn_db); end
  endtask

  // Two-cycle glitch on run/halt must be filtered out completely.
  task automatic test_glitch;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      btn_n    = (k < 2) ? 4'b1110 : 4'b1111;
      cpu_sync = 1'b0;
      #1;
      n_cmp++; if (btn_db !== 4'h0) begin n_err++; $display("FAIL glitch_btn_db k=%0d got=%h exp=0", k, btn_db); end
      n_cmp++; if (cpu_en !== 1'b1) begin n_err++; $display("FAIL glitch_cpu_en k=%0d got=%b exp=1", k, cpu_en); end
      n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL glitch_halted k=%0d got=%b exp=0", k, halted); end
    end
  endtask

  // Held run/halt with a fetch every third cycle: one halt, frozen on fetch.
  task automatic test_halt;
    logic       exp_en;
    logic       exp_h;
    logic [3:0] exp_db;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      btn_n    = (k < 20) ? 4'b1110 : 4'b1111;
      cpu_sync = ((k % 3) == 2);
      #1;
      exp_en = (k < 8);
      exp_h  = (k >= 9);
      exp_db = (k >= 6 && k < 26) ? 4'b0001 : 4'b0000;
      n_cmp++; if (cpu_en !== exp_en) begin n_err++; $display("FAIL halt_cpu_en k=%0d got=%b exp=%b", k, cpu_en, exp_en); end
      n_cmp++; if (halted !== exp_h)  begin n_err++; $display("FAIL halt_halted k=%0d got=%b exp=%b", k, halted, exp_h); end
      n_cmp++; if (btn_db !== exp_db) begin n_err++; $display("FAIL halt_btn_db k=%0d got=%h exp=%h", k, btn_db, exp_db); end
    end
  endtask

  // Single step from HALTED with sync pattern 1,0,0,1 once stepping.
  task automatic test_step;
    logic       exp_en;
    logic       exp_h;
    logic [3:0] exp_db;
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      btn_n    = (k < 8) ? 4'b1101 : 4'b1111;
      cpu_sync = (k == 7) || (k == 10);
      #1;
      exp_en = (k >= 7 && k <= 9);
      exp_h  = !(k >= 7 && k <= 10);
      exp_db = (k >= 6 && k < 14) ? 4'b0010 : 4'b0000;
      n_cmp++; if (cpu_en !== exp_en) begin n_err++; $display("FAIL step_cpu_en k=%0d got=%b exp=%b", k, cpu_en, exp_en); end
      n_cmp++; if (halted !== exp_h)  begin n_err++; $display("FAIL step_halted k=%0d got=%b exp=%b", k, halted, exp_h); end
      n_cmp++; if (btn_db !== exp_db) begin n_err++; $display("FAIL step_btn_db k=%0d got=%h exp=%h", k, btn_db, exp_db); end
    end
  endtask

  // Five display-select presses while halted: 1,2,3,0,1 and FSM untouched.
  task automatic test_disp_sel;
    logic [1:0] prev_sel;
    logic [1:0] exp_sel;
    prev_sel = 2'd0;
    for (int p = 0; p < 5; p++) begin
      for (int k = 0; k < 16; k++) begin
        @(negedge clk);
        btn_n    = (k < 8) ? 4'b1011 : 4'b1111;
        cpu_sync = 1'b0;
        #1;
        exp_sel = (k >= 7) ? prev_sel + 2'd1 : prev_sel;
        n_cmp++; if (disp_sel !== exp_sel) begin n_err++; $display("FAIL disp_sel p=%0d k=%0d got=%0d exp=%0d", p, k, disp_sel, exp_sel); end
        n_cmp++; if (halted !== 1'b1) begin n_err++; $display("FAIL disp_halted p=%0d k=%0d got=%b exp=1", p, k, halted); end
        n_cmp++; if (cpu_en !== 1'b0) begin n_err++; $display("FAIL disp_cpu_en p=%0d k=%0d got=%b exp=0", p, k, cpu_en); end
      end
      prev_sel = prev_sel + 2'd1;
    end
    n_cmp++; if (disp_sel !== 2'd1) begin n_err++; $display("FAIL disp_sel_final got=%0d exp=1", disp_sel); end
  endtask

  // Enter STEP, then soft reset twice: 3-cycle pulse each, state forced to RUN.
  task automatic test_soft_reset;
    logic exp_en;
    logic exp_h;
    logic exp_rst;
    // Step press with no fetch: the core stays in STEP with cpu_en=1.
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      btn_n    = (k < 8) ? 4'b1101 : 4'b1111;
      cpu_sync = 1'b0;
      #1;
      exp_en = (k >= 7);
      exp_h  = (k < 7);
      n_cmp++; if (cpu_en !== exp_en) begin n_err++; $display("FAIL sr_enter_cpu_en k=%0d got=%b exp=%b", k, cpu_en, exp_en); end
      n_cmp++; if (halted !== exp_h)  begin n_err++; $display("FAIL sr_enter_halted k=%0d got=%b exp=%b", k, halted, exp_h); end
    end
    // Soft reset from STEP; sync=1 afterwards would freeze STEP but not RUN.
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      btn_n    = (j < 8) ? 4'b0111 : 4'b1111;
      cpu_sync = (j >= 7);
      #1;
      exp_rst = (j >= 7 && j <= 9);
      n_cmp++; if (cpu_rst !== exp_rst) begin n_err++; $display("FAIL sr1_cpu_rst j=%0d got=%b exp=%b", j, cpu_rst, exp_rst); end
      n_cmp++; if (cpu_en !== 1'b1)     begin n_err++; $display("FAIL sr1_cpu_en j=%0d got=%b exp=1", j, cpu_en); end
      n_cmp++; if (halted !== 1'b0)     begin n_err++; $display("FAIL sr1_halted j=%0d got=%b exp=0", j, halted); end
      n_cmp++; if (disp_sel !== 2'd1)   begin n_err++; $display("FAIL sr1_disp_sel j=%0d got=%0d exp=1", j, disp_sel); end
    end
    // Second soft reset: a fresh 3-cycle pulse timed from the new event.
    for (int m = 0; m < 16; m++) begin
      @(negedge clk);
      btn_n    = (m < 8) ? 4'b0111 : 4'b1111;
      cpu_sync = 1'b1;
      #1;
      exp_rst = (m >= 7 && m <= 9);
      n_cmp++; if (cpu_rst !== exp_rst) begin n_err++; $display("FAIL sr2_cpu_rst m=%0d got=%b exp=%b", m, cpu_rst, exp_rst); end
      n_cmp++; if (cpu_en !== 1'b1)     begin n_err++; $display("FAIL sr2_cpu_en m=%0d got=%b exp=1", m, cpu_en); end
    end
  endtask

  // Asynchronous reset while waiting in HALT_PEND.
  task automatic test_async_reset;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      btn_n    = 4'b1110;
      cpu_sync = 1'b0;
      #1;
    end
    n_cmp++; if (cpu_en !== 1'b1) begin n_err++; $display("FAIL ar_pend_cpu_en got=%b exp=1", cpu_en); end
    n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL ar_pend_halted got=%b exp=0", halted); end
    n_cmp++; if (btn_db !== 4'h1) begin n_err++; $display("FAIL ar_pend_btn_db got=%h exp=1", btn_db); end
    @(negedge clk);
    cpu_sync = 1'b1;
    #1;
    n_cmp++; if (cpu_en !== 1'b0) begin n_err++; $display("FAIL ar_pend_frozen got=%b exp=0", cpu_en); end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++; if (cpu_en !== 1'b1)   begin n_err++; $display("FAIL ar_cpu_en got=%b exp=1", cpu_en); end
    n_cmp++; if (halted !== 1'b0)   begin n_err++; $display("FAIL ar_halted got=%b exp=0", halted); end
    n_cmp++; if (disp_sel !== 2'd0) begin n_err++; $display("FAIL ar_disp_sel got=%0d exp=0", disp_sel); end
    n_cmp++; if (cpu_rst !== 1'b0)  begin n_err++; $display("FAIL ar_cpu_rst got=%b exp=0", cpu_rst); end
    n_cmp++; if (btn_db !== 4'h0)   begin n_err++; $display("FAIL ar_btn_db got=%h exp=0", btn_db); end
    @(negedge clk);
    reset    = 1'b0;
    btn_n    = 4'b1111;
    cpu_sync = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      n_cmp++; if (cpu_en !== 1'b1) begin n_err++; $display("FAIL ar_after_cpu_en k=%0d got=%b exp=1", k, cpu_en); end
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    reset    = 1'b1;
    btn_n    = 4'b1111;
    cpu_sync = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    test_reset();
    test_glitch();
    test_halt();
    test_step();
    test_disp_sel();
    test_soft_reset();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
